// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: round-robin two-source frame arbiter driving a MAC Tx write/send handshake; define ETH_TX_ARB_TIMEOUT_EN for a wait-state watchdog
module eth_tx_arbiter #(
  parameter int MAX_LEN        = 1514,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [15:0] len0,
  input  logic [15:0] len1,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  output logic [1:0]  rd,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic        err,
  output logic        busy,
  output logic        tx_clear,
  output logic        tx_valid,
  output logic        tx_send,
  output logic [15:0] tx_data_count,
  output logic [31:0] tx_data_in,
  input  logic        tx_done,
  input  logic        tx_ready_to_write,
  input  logic        tx_ready_to_send
);
  typedef enum logic [3:0] {IDLE, ARB, WAIT_DONE, REQ_WR, WRITE, WAIT_RTS, SEND, WAIT_TX, FIN} state_t;
  state_t state_q, state_d;
  logic [1:0] gnt_q, gnt_d, rd_q, rd_d, done_q, done_d, sc_q, sc_d;
  logic last_q, last_d, low_q, low_d, err_q, err_d;
  logic tx_clear_q, tx_clear_d, tx_valid_q, tx_valid_d, tx_send_q, tx_send_d;
  logic [14:0] cnt_q, cnt_d;
  logic [15:0] len_q, len_d, tx_data_count_q, tx_data_count_d, wlen;
  logic [31:0] tx_data_in_q, tx_data_in_d;
  logic win, bad, tmo_hit;
  assign win  = (req == 2'b11) ? ~last_q : req[1];
  assign wlen = win ? len1 : len0;
  assign bad  = (wlen == 16'd0) || (int'(wlen) > MAX_LEN);
`ifdef ETH_TX_ARB_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
  assign tmo_d   = (state_d == state_q) ? tmo_q + 32'd1 : 32'd0;
  assign tmo_hit = tmo_q == 32'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tmo_q <= '0;
    else tmo_q <= tmo_d;
`else
  assign tmo_hit = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    last_d = last_q;
    len_d = len_q;
    cnt_d = cnt_q;
    sc_d = sc_q;
    low_d = low_q;
    err_d = 1'b0;
    tx_data_count_d = tx_data_count_q;
    tx_data_in_d = tx_data_in_q;
    case (state_q)
      IDLE: state_d = |req ? ARB : IDLE;
      ARB: begin
        gnt_d = |req ? (win ? 2'b10 : 2'b01) : 2'b00;
        len_d = wlen;
        err_d = |req && bad;
        state_d = !(|req) ? IDLE : bad ? FIN : WAIT_DONE;
      end
      WAIT_DONE: begin
        tx_data_count_d = tx_done ? len_q : tx_data_count_q;
        state_d = tx_done ? REQ_WR : WAIT_DONE;
      end
      REQ_WR: begin
        cnt_d = 15'((17'(len_q) + 17'd3) >> 2);
        state_d = tx_ready_to_write ? WRITE : REQ_WR;
      end
      WRITE: begin
        tx_data_in_d = gnt_q[1] ? data1 : data0;
        cnt_d = cnt_q - 15'd1;
        state_d = (cnt_q == 15'd1) ? WAIT_RTS : WRITE;
      end
      WAIT_RTS: state_d = tx_ready_to_send ? SEND : WAIT_RTS;
      SEND: begin
        sc_d = sc_q + 2'd1;
        state_d = (sc_q == 2'd3) ? WAIT_TX : SEND;
      end
      WAIT_TX: begin
        low_d = low_q | ~tx_done;
        state_d = (low_q && tx_done) ? FIN : WAIT_TX;
      end
      FIN: begin
        state_d = IDLE;
        gnt_d = 2'b00;
        last_d = gnt_q[1];
        low_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (tmo_hit && state_d == state_q && state_q inside {WAIT_DONE, REQ_WR, WAIT_RTS, WAIT_TX}) begin
      state_d = FIN;
      err_d = 1'b1;
    end
    rd_d = (state_d == WRITE) ? gnt_d : 2'b00;
    done_d = (state_d == FIN) ? gnt_d : 2'b00;
    tx_clear_d = state_d == IDLE;
    tx_valid_d = (state_d inside {REQ_WR, WRITE}) || (state_q == WRITE && state_d == WAIT_RTS);
    tx_send_d = state_d == SEND;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q <= '0;
      rd_q <= '0;
      done_q <= '0;
      sc_q <= '0;
      last_q <= 1'b1;
      low_q <= 1'b0;
      err_q <= 1'b0;
      tx_clear_q <= 1'b1;
      tx_valid_q <= 1'b0;
      tx_send_q <= 1'b0;
      cnt_q <= '0;
      len_q <= '0;
      tx_data_count_q <= '0;
      tx_data_in_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      rd_q <= rd_d;
      done_q <= done_d;
      sc_q <= sc_d;
      last_q <= last_d;
      low_q <= low_d;
      err_q <= err_d;
      tx_clear_q <= tx_clear_d;
      tx_valid_q <= tx_valid_d;
      tx_send_q <= tx_send_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      tx_data_count_q <= tx_data_count_d;
      tx_data_in_q <= tx_data_in_d;
    end
  assign rd = rd_q;
  assign gnt = gnt_q;
  assign done = done_q;
  assign err = err_q;
  assign busy = state_q != IDLE;
  assign tx_clear = tx_clear_q;
  assign tx_valid = tx_valid_q;
  assign tx_send = tx_send_q;
  assign tx_data_count = tx_data_count_q;
  assign tx_data_in = tx_data_in_q;
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: directed frame vectors and corner sequences against a behavioural MAC and requester model
module tb_eth_tx_arbiter;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [1:0] req = 2'b00;
  logic [15:0] len0 = 16'd0, len1 = 16'd0;
  logic [31:0] data0 = 32'hA000_0000, data1 = 32'hB000_0000;
  logic tx_done = 1'b1, tx_ready_to_write = 1'b1, tx_ready_to_send = 1'b1;
  logic [1:0] rd, gnt, done;
  logic err, busy, tx_clear, tx_valid, tx_send;
  logic [15:0] tx_data_count;
  logic [31:0] tx_data_in;
  int n_chk = 0, n_fail = 0;
  int r_nrd, r_nsend, r_cyc, r_last_rd, r_fall, r_bad;
  logic [1:0] r_done;
  logic r_err, r_vseen;
  always #5 clk = ~clk;
  eth_tx_arbiter #(.MAX_LEN(1514), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .len0(len0), .len1(len1),
    .data0(data0), .data1(data1), .rd(rd), .gnt(gnt), .done(done), .err(err),
    .busy(busy), .tx_clear(tx_clear), .tx_valid(tx_valid), .tx_send(tx_send),
    .tx_data_count(tx_data_count), .tx_data_in(tx_data_in), .tx_done(tx_done),
    .tx_ready_to_write(tx_ready_to_write), .tx_ready_to_send(tx_ready_to_send)
  );
  typedef struct {
    logic [1:0] rq;
    logic [15:0] l0;
    logic [15:0] l1;
    int words;
    logic [1:0] dn;
    logic er;
  } vec_t;
  vec_t vecs[9];
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  function automatic logic [63:0] outs();
    return {5'b0, rd, gnt, done, err, busy, tx_clear, tx_valid, tx_send, tx_data_count, tx_data_in};
  endfunction
  task automatic go(input int max, input bit keep);
    int post;
    logic [1:0] prd;
    logic [31:0] pdata;
    logic pv;
    r_nrd = 0; r_nsend = 0; r_cyc = -1; r_last_rd = -1; r_fall = -1; r_bad = 0;
    r_done = 2'b00; r_err = 1'b0; r_vseen = 1'b0;
    post = 0; prd = 2'b00; pdata = '0; pv = 1'b0;
    for (int c = 0; c < max; c++) begin
      @(negedge clk);
      if (prd != 2'b00 && tx_data_in !== pdata) r_bad++;
      if (prd[0]) data0 = data0 + 32'd1;
      if (prd[1]) data1 = data1 + 32'd1;
      if (rd != 2'b00) begin
        r_nrd++;
        r_last_rd = c;
      end
      prd = rd;
      pdata = rd[1] ? data1 : data0;
      if (tx_send) begin
        r_nsend++;
        tx_done = 1'b0;
        post = 4;
      end else if (post > 0) begin
        post--;
        if (post == 0) tx_done = 1'b1;
      end
      if (tx_valid) r_vseen = 1'b1;
      if (pv && !tx_valid) r_fall = c;
      pv = tx_valid;
      if (done != 2'b00) begin
        r_done = done;
        r_err = err;
        r_cyc = c;
        if (!keep) req = req & ~done;
        return;
      end
    end
  endtask
  initial begin
    logic seen;
    vecs[0] = '{2'b01, 16'd60,   16'd0,    15,  2'b01, 1'b0};
    vecs[1] = '{2'b10, 16'd0,    16'd0,    0,   2'b10, 1'b1};
    vecs[2] = '{2'b01, 16'd61,   16'd0,    16,  2'b01, 1'b0};
    vecs[3] = '{2'b10, 16'd0,    16'd1,    1,   2'b10, 1'b0};
    vecs[4] = '{2'b01, 16'd4,    16'd0,    1,   2'b01, 1'b0};
    vecs[5] = '{2'b10, 16'd0,    16'd5,    2,   2'b10, 1'b0};
    vecs[6] = '{2'b01, 16'd1514, 16'd0,    379, 2'b01, 1'b0};
    vecs[7] = '{2'b10, 16'd0,    16'd1515, 0,   2'b10, 1'b1};
    vecs[8] = '{2'b01, 16'd0,    16'd1514, 0,   2'b01, 1'b1};
    #3 rst_n = 1'b0;
    #1 chk("reset_outputs", outs(), {5'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req = 2'b11; len0 = 16'd64; len1 = 16'd64;
    go(2000, 1'b0);
    chk("both_first_done", r_done, 2'b01);
    chk("both_first_words", r_nrd, 16);
    chk("both_first_err", r_err, 1'b0);
    go(2000, 1'b0);
    chk("both_second_done", r_done, 2'b10);
    chk("both_second_words", r_nrd, 16);
    req = 2'b11;
    go(2000, 1'b1);
    chk("rr_first_done", r_done, 2'b01);
    go(2000, 1'b0);
    chk("rr_pending_other_wins", r_done, 2'b10);
    go(2000, 1'b0);
    chk("rr_reasserted_served", r_done, 2'b01);
    for (int i = 0; i < 9; i++) begin
      req = vecs[i].rq; len0 = vecs[i].l0; len1 = vecs[i].l1;
      go(2000, 1'b0);
      chk($sformatf("v%0d_done", i), r_done, vecs[i].dn);
      chk($sformatf("v%0d_err", i), r_err, vecs[i].er);
      chk($sformatf("v%0d_words", i), r_nrd, vecs[i].words);
      chk($sformatf("v%0d_send_cycles", i), r_nsend, vecs[i].er ? 0 : 4);
      chk($sformatf("v%0d_data", i), r_bad, 0);
      if (vecs[i].er) begin
        chk($sformatf("v%0d_err_latency", i), r_cyc inside {[0:2]}, 1'b1);
        chk($sformatf("v%0d_no_valid", i), r_vseen, 1'b0);
      end else begin
        chk($sformatf("v%0d_count", i), tx_data_count, vecs[i].rq[1] ? vecs[i].l1 : vecs[i].l0);
        chk($sformatf("v%0d_valid_fall", i), r_fall, r_last_rd + 2);
      end
      @(negedge clk);
      chk($sformatf("v%0d_idle", i), {busy, tx_clear, gnt}, 4'b0100);
    end
    req = 2'b01; len0 = 16'd64;
    for (int k = 0; k < 50 && rd == 2'b00; k++) @(negedge clk);
    chk("reached_write", rd, 2'b01);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_write", outs(), {5'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0});
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | (|done);
    end
    chk("no_done_in_reset", seen, 1'b0);
    rst_n = 1'b1;
    #1 chk("idle_after_release", {busy, tx_clear}, 2'b01);
    go(2000, 1'b0);
    chk("post_reset_done", r_done, 2'b01);
    chk("post_reset_words", r_nrd, 16);
    chk("post_reset_err", r_err, 1'b0);
`ifdef ETH_TX_ARB_TIMEOUT_EN
    tx_ready_to_send = 1'b0;
    req = 2'b01; len0 = 16'd8;
    go(2000, 1'b0);
    chk("tmo_done", r_done, 2'b01);
    chk("tmo_err", r_err, 1'b1);
    chk("tmo_no_send", r_nsend, 0);
    chk("tmo_latency", r_cyc - r_last_rd, 101);
    tx_ready_to_send = 1'b1;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/eth_tx_arbiter.md
ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 Parameter MAX_LEN, default 1514, maximum accepted frame length in bytes.
REQ-002 Parameter TIMEOUT_CYCLES, default 65535, watchdog limit in clk cycles; used only with ETH_TX_ARB_TIMEOUT_EN.
REQ-003 clk  in  1  100 MHz system clock; all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req  in  2  per-requester frame request, level, held until its done pulse.
REQ-006 len0, len1  in  16  frame length in bytes per requester, stable while req is high.
REQ-007 data0, data1  in  32  next frame word per requester, valid while req is high.
REQ-008 rd  out  2  one-hot word-pop strobe to the granted requester.
REQ-009 gnt  out  2  one-hot grant, held from arbitration to done.
REQ-010 done  out  2  one-cycle end-of-frame pulse per requester.
REQ-011 err  out  1  one-cycle pulse coincident with done for a rejected or timed-out frame.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 tx_clear  out  1; tx_valid  out  1; tx_send  out  1; tx_data_count  out  16; tx_data_in  out  32: MAC Tx controls.
REQ-014 tx_done  in  1; tx_ready_to_write  in  1; tx_ready_to_send  in  1: MAC Tx status.

Function
REQ-015 States: IDLE, ARB, WAIT_DONE, REQ_WR, WRITE, WAIT_RTS, SEND, WAIT_TX, FIN.
REQ-016 IDLE->ARB when any req bit is high; ARB lasts one cycle and registers gnt.
REQ-017 Arbitration is round-robin: single request wins; if both are high, the requester not granted last wins; the pointer resets to favour requester 0.
REQ-018 In ARB, len of 0 or greater than MAX_LEN -> FIN with err=1; no MAC signal toggles.
REQ-019 tx_clear is 1 in IDLE and 0 in all other states.
REQ-020 WAIT_DONE: wait for tx_done=1, then load tx_data_count=len and go to REQ_WR.
REQ-021 REQ_WR: tx_valid=1; on tx_ready_to_write=1 go to WRITE.
REQ-022 Word count is (len+3)>>2, computed in 17 bits, so 1..4 bytes give 1 word and 1514 gives 379.
REQ-023 WRITE: one word per cycle with no gaps; rd is high in the cycle data is captured; tx_data_in is registered, so it updates the cycle after rd; tx_valid stays 1 through the last word and is 0 the following cycle.
REQ-024 WAIT_RTS: wait for tx_ready_to_send=1, then go to SEND.
REQ-025 SEND: tx_send=1 for exactly 4 clk cycles, covering two 50 MHz edges.
REQ-026 WAIT_TX: wait for tx_done=0, then tx_done=1, then go to FIN.
REQ-027 FIN: done[g]=1 for one cycle, gnt clears, rotate pointer, return to IDLE.
REQ-028 Dropping req mid-frame does not abort the frame; it completes with the current data.
REQ-029 Requests arriving during a frame are queued by level and arbitrated after FIN.
REQ-030 The granted requester reasserting req in FIN loses to a pending other requester.

Reset
REQ-031 While rst_n=0: state=IDLE, rd=0, gnt=0, done=0, err=0, busy=0, tx_clear=1, tx_valid=0, tx_send=0, tx_data_count=0, tx_data_in=0, pointer favours requester 0.
REQ-032 Reset mid-frame abandons the frame with no done pulse; after release the block takes ≥1 cycle in IDLE with tx_clear=1.

Configuration
REQ-033 With ETH_TX_ARB_TIMEOUT_EN defined, a counter runs in WAIT_DONE, REQ_WR, WAIT_RTS and WAIT_TX and resets on each state entry; reaching TIMEOUT_CYCLES -> FIN with err=1, tx_valid=0, tx_send=0.
REQ-034 Without ETH_TX_ARB_TIMEOUT_EN, the counter is absent and wait states wait indefinitely.

Verification
REQ-035 req=01, len0=60, MAC model ready -> tx_data_count=60, 15 rd pulses, tx_send high 4 cycles, done=01, err=0.
REQ-036 req=11 from reset, both len=64 -> requester 0 served first, then requester 1; 16 words each; done order 01 then 10.
REQ-037 len1=0 with req=10 -> done=10 and err=1 within 3 cycles; tx_valid and tx_send stay 0.
REQ-038 len0=61 -> 16 words written; len0=1514 -> 379 words; tx_valid falls the cycle after the last word.
REQ-039 rst_n pulsed low mid-WRITE -> all outputs at reset values asynchronously, no done; a new req=01 completes normally.
REQ-040 With ETH_TX_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100, tx_ready_to_send held 0 -> err=1 and done=01 exactly 100 cycles after entering WAIT_RTS.
